// File: rtl/jpu_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// bus handshake states and sizing constants.
package jpu;

  localparam int unsigned INTC_NLINE = 8;   // cause lines feeding CP0 ints_in
  localparam int unsigned INTC_RTW   = 3;   // route field width per source
  localparam int unsigned INTC_RPW   = 8;   // route fields per route word
  localparam int unsigned INTC_DW    = 32;  // register bus data width

  typedef enum logic [2:0] {
    INTC_PENDING  = 3'd0,
    INTC_ENABLE   = 3'd1,
    INTC_EDGE     = 3'd2,
    INTC_POLARITY = 3'd3,
    INTC_CLEAR    = 3'd4,
    INTC_ROUTE_LO = 3'd5,
    INTC_ROUTE_HI = 3'd6,
    INTC_CLAIM    = 3'd7
  } intc_reg_e;

  typedef enum logic {
    INTC_IDLE = 1'b0,
    INTC_ACK  = 1'b1
  } intc_state_e;

endpackage

// File: rtl/intc_cond.sv
// Source conditioning: synchroniser, polarity XOR and rising-edge detect.
// INTC_SYNC_EN selects a 2-flop synchroniser; otherwise a single register.
module intc_cond #(
  parameter int unsigned NSRC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] polarity,
  output logic [NSRC-1:0] act,
  output logic [NSRC-1:0] rise
);

  logic [NSRC-1:0] sync_q;
  logic [NSRC-1:0] act_q;

`ifdef INTC_SYNC_EN
  logic [NSRC-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= src;
      sync_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= src;
  end
`endif

  // Polarity applies live, so a POLARITY write can itself produce an edge.
  assign act  = sync_q ^ polarity;
  assign rise = act & ~act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_q <= '0;
    else        act_q <= act;
  end

endmodule

// File: rtl/intc.sv
// Memory-mapped external interrupt controller driving CP0 ints_in.
// Build option INTC_SYNC_EN (see intc_cond) selects synchroniser depth.
module intc
  import jpu::*;
#(
  parameter int unsigned NSRC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC-1:0]       src,
  input  logic                  bus_req,
  input  logic                  bus_we,
  input  logic [2:0]            bus_addr,
  input  logic [INTC_DW-1:0]    bus_wdata,
  output logic [INTC_DW-1:0]    bus_rdata,
  output logic                  bus_ack,
  output logic [INTC_NLINE-1:0] ints_out
);

  localparam int unsigned WDW = INTC_RTW * INTC_RPW;

  intc_state_e           state_q, state_d;
  logic                  take, commit;
  logic                  wr_q;
  intc_reg_e             addr_q;
  logic [WDW-1:0]        wdata_q;
  logic [INTC_DW-1:0]    rd_val, rdata_q;
  logic [NSRC-1:0]       pending_q, enable_q, edge_q, polarity_q;
  logic [NSRC-1:0]       act, rise, clr, pend_d, hit;
  logic [INTC_RTW-1:0]   route_q [NSRC];
  logic [INTC_NLINE-1:0] ints_d, ints_q;
  logic                  unused_wdata;

  assign unused_wdata = ^bus_wdata[INTC_DW-1:WDW];

  intc_cond #(.NSRC(NSRC)) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .src      (src),
    .polarity (polarity_q),
    .act      (act),
    .rise     (rise)
  );

  // Bus handshake: accept in IDLE, one ACK cycle, write commits on leaving ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INTC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      INTC_IDLE: begin
        if (bus_req) begin
          state_d = INTC_ACK;
          take    = 1'b1;
        end
      end
      INTC_ACK: state_d = INTC_IDLE;
      default:  state_d = INTC_IDLE;
    endcase
  end

  assign bus_ack   = (state_q == INTC_ACK);
  assign commit    = bus_ack & wr_q;
  assign bus_rdata = rdata_q;
  assign ints_out  = ints_q;
  assign hit       = pending_q & enable_q;

  // Read mux over pre-edge register state.
  always_comb begin
    rd_val = '0;
    case (intc_reg_e'(bus_addr))
      INTC_PENDING:  rd_val = INTC_DW'(pending_q);
      INTC_ENABLE:   rd_val = INTC_DW'(enable_q);
      INTC_EDGE:     rd_val = INTC_DW'(edge_q);
      INTC_POLARITY: rd_val = INTC_DW'(polarity_q);
      INTC_ROUTE_LO: begin
        for (int i = 0; i < int'(NSRC); i++)
          if (i < int'(INTC_RPW)) rd_val[(i % int'(INTC_RPW)) * 3 +: 3] = route_q[i];
      end
      INTC_ROUTE_HI: begin
        for (int i = 0; i < int'(NSRC); i++)
          if (i >= int'(INTC_RPW)) rd_val[(i % int'(INTC_RPW)) * 3 +: 3] = route_q[i];
      end
      INTC_CLAIM: begin
        for (int i = int'(NSRC) - 1; i >= 0; i--)
          if (hit[i]) rd_val = INTC_DW'(i + 1);
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= INTC_PENDING;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= (take && !bus_we) ? rd_val : '0;
      if (take) begin
        wr_q    <= bus_we;
        addr_q  <= intc_reg_e'(bus_addr);
        wdata_q <= bus_wdata[WDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q   <= '0;
      edge_q     <= '0;
      polarity_q <= '0;
      for (int i = 0; i < int'(NSRC); i++) route_q[i] <= '0;
    end else if (commit) begin
      case (addr_q)
        INTC_ENABLE:   enable_q   <= wdata_q[NSRC-1:0];
        INTC_EDGE:     edge_q     <= wdata_q[NSRC-1:0];
        INTC_POLARITY: polarity_q <= wdata_q[NSRC-1:0];
        INTC_ROUTE_LO: begin
          for (int i = 0; i < int'(NSRC); i++)
            if (i < int'(INTC_RPW)) route_q[i] <= wdata_q[(i % int'(INTC_RPW)) * 3 +: 3];
        end
        INTC_ROUTE_HI: begin
          for (int i = 0; i < int'(NSRC); i++)
            if (i >= int'(INTC_RPW)) route_q[i] <= wdata_q[(i % int'(INTC_RPW)) * 3 +: 3];
        end
        default: ;
      endcase
    end
  end

  // Edge-mode bits are sticky until cleared; a same-edge rise beats the clear.
  assign clr    = (commit && addr_q == INTC_CLEAR) ? wdata_q[NSRC-1:0] : '0;
  assign pend_d = (edge_q & ((pending_q & ~clr) | rise)) | (~edge_q & act);

  always_comb begin
    ints_d = '0;
    for (int j = 0; j < int'(INTC_NLINE); j++)
      for (int i = 0; i < int'(NSRC); i++)
        if (hit[i] && route_q[i] == INTC_RTW'(j)) ints_d[j] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      ints_q    <= '0;
    end else begin
      pending_q <= pend_d;
      ints_q    <= ints_d;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: per-cycle reference model plus directed
// register/latency checks with hand-computed values.
module tb_intc;

`ifdef INTC_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] src = '0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  ints_out;

  int n_cmp = 0;
  int n_bad = 0;

  intc #(.NSRC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .ints_out  (ints_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_en = '0, m_edg = '0, m_pol = '0, m_pend = '0, m_aprev = '0;
  logic [15:0] m_d1 = '0, m_d2 = '0;
  logic [2:0]  m_route [16];
  logic [7:0]  m_ints = '0;
  logic        m_ack = 1'b0, m_wr = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [31:0] m_wdata = '0, m_rdata = '0;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r = {16'h0, m_pend};
      3'd1: r = {16'h0, m_en};
      3'd2: r = {16'h0, m_edg};
      3'd3: r = {16'h0, m_pol};
      3'd5: for (int i = 0; i < 8; i++) r[3*i +: 3] = m_route[i];
      3'd6: for (int i = 0; i < 8; i++) r[3*i +: 3] = m_route[i+8];
      3'd7: for (int i = 0; i < 16; i++)
              if (r == 0 && m_pend[i] && m_en[i]) r = 32'(i + 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] act, rise, clr, np;
    logic [7:0]  ni;
    if (!rst_n) begin
      m_en = '0; m_edg = '0; m_pol = '0; m_pend = '0; m_aprev = '0;
      m_d1 = '0; m_d2 = '0; m_ints = '0; m_ack = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      for (int i = 0; i < 16; i++) m_route[i] = '0;
    end else begin
      act  = ((S == 2) ? m_d2 : m_d1) ^ m_pol;
      rise = act & ~m_aprev;
      clr  = (m_ack && m_wr && m_addr == 3'd4) ? m_wdata[15:0] : 16'h0;
      for (int i = 0; i < 16; i++)
        np[i] = m_edg[i] ? ((m_pend[i] & ~clr[i]) | rise[i]) : act[i];
      ni = '0;
      for (int i = 0; i < 16; i++)
        if (m_pend[i] && m_en[i]) ni[m_route[i]] = 1'b1;
      if (m_ack) begin
        if (m_wr) begin
          case (m_addr)
            3'd1: m_en  = m_wdata[15:0];
            3'd2: m_edg = m_wdata[15:0];
            3'd3: m_pol = m_wdata[15:0];
            3'd5: for (int i = 0; i < 8; i++) m_route[i]   = m_wdata[3*i +: 3];
            3'd6: for (int i = 0; i < 8; i++) m_route[i+8] = m_wdata[3*i +: 3];
            default: ;
          endcase
        end
        m_ack = 1'b0; m_rdata = '0;
      end else if (bus_req) begin
        m_rdata = bus_we ? 32'h0 : m_read(bus_addr);
        m_wr = bus_we; m_addr = bus_addr; m_wdata = bus_wdata;
        m_ack = 1'b1;
      end else begin
        m_rdata = '0;
      end
      m_pend = np; m_ints = ni; m_aprev = act; m_d2 = m_d1; m_d1 = src;
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if (ints_out !== m_ints) begin
      n_bad++;
      $display("FAIL model_ints_out t=%0t got %h want %h", $time, ints_out, m_ints);
    end
    n_cmp++;
    if (bus_ack !== m_ack) begin
      n_bad++;
      $display("FAIL model_bus_ack t=%0t got %b want %b", $time, bus_ack, m_ack);
    end
    n_cmp++;
    if (bus_rdata !== m_rdata) begin
      n_bad++;
      $display("FAIL model_bus_rdata t=%0t got %h want %h", $time, bus_rdata, m_rdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    logic ok;
    ok = 1'b0;
    bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(posedge clk); #1;
      ok = bus_ack;
    end
    rd = bus_rdata;
    bus_req = 1'b0; bus_we = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout: got no ack expected ack for addr %0d", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(1'b0, a, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acks;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    step(1);

    // Reset state
    chk("rst_ints_out", 32'(ints_out), 32'h0);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), 32'h0);

    // Level mode latency on src[0]
    wr(3'd1, 32'h1);
    wr(3'd5, 32'h0);
    src[0] = 1'b1;
    step(S + 1);
    chk("lvl_rise_early", 32'(ints_out), 32'h0);
    step(1);
    chk("lvl_rise", 32'(ints_out), 32'h1);
    src[0] = 1'b0;
    step(S + 1);
    chk("lvl_fall_early", 32'(ints_out), 32'h1);
    step(1);
    chk("lvl_fall", 32'(ints_out), 32'h0);

    // Edge mode on src[2], routed to line 3
    wr(3'd2, 32'h4);
    wr(3'd1, 32'h4);
    wr(3'd5, 32'hC0);
    src[2] = 1'b1;
    step(1);
    src[2] = 1'b0;
    step(S + 3);
    rd_chk("edge_pending", 3'd0, 32'h4);
    chk("edge_ints_held", 32'(ints_out), 32'h8);
    wr(3'd4, 32'h4);
    chk("clr_ints_prev", 32'(ints_out), 32'h8);
    step(1);
    chk("clr_ints", 32'(ints_out), 32'h0);
    rd_chk("clr_pending", 3'd0, 32'h0);

    // Clear commit coincides with a new rising edge: set wins
    src[2] = 1'b1;
    if (S == 2) step(1);
    wr(3'd4, 32'h4);
    rd_chk("clr_vs_set_pending", 3'd0, 32'h4);
    src[2] = 1'b0;
    wr(3'd4, 32'h4);
    rd_chk("clr_again_pending", 3'd0, 32'h0);

    // CLAIM priority among sources 3 and 9
    wr(3'd2, 32'h0208);
    wr(3'd1, 32'h0208);
    src[3] = 1'b1; src[9] = 1'b1;
    step(1);
    src[3] = 1'b0; src[9] = 1'b0;
    step(S + 2);
    rd_chk("pend_3_9", 3'd0, 32'h0208);
    rd_chk("claim_both", 3'd7, 32'd4);
    wr(3'd1, 32'h0200);
    rd_chk("claim_9", 3'd7, 32'd10);
    wr(3'd1, 32'h0);
    rd_chk("claim_none", 3'd7, 32'd0);
    wr(3'd4, 32'h0208);

    // Active-low source 5 in level mode, routed to line 5; width masking
    wr(3'd2, 32'h0);
    wr(3'd5, 32'h0002_8000);
    wr(3'd3, 32'h0020);
    wr(3'd1, 32'h0020);
    step(S + 2);
    chk("pol_ints", 32'(ints_out), 32'h20);
    rd_chk("pol_readback", 3'd3, 32'h0020);
    rd_chk("route_lo_readback", 3'd5, 32'h0002_8000);
    wr(3'd6, 32'hFFFF_FFFF);
    rd_chk("route_hi_mask", 3'd6, 32'h00FF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    rd_chk("enable_mask", 3'd1, 32'h0000_FFFF);
    rd_chk("clear_reads0", 3'd4, 32'h0);
    step(2);
    chk("pol_ints_after", 32'(ints_out), 32'h20);

    // bus_req held high: one ack every two cycles
    acks = 0;
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (bus_ack) acks++;
    end
    bus_req = 1'b0;
    chk("held_req_acks", 32'(acks), 32'd3);
    step(1);

    // Reset during the ack cycle of a write
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd3; bus_wdata = 32'h00FF;
    step(1);
    chk("mid_ack_seen", 32'(bus_ack), 32'h1);
    #2 rst_n = 1'b0;
    bus_req = 1'b0; bus_we = 1'b0;
    #3 rst_n = 1'b1;
    step(1);
    chk("mid_ack_lost", 32'(bus_ack), 32'h0);
    rd_chk("mid_rst_pol", 3'd3, 32'h0);
    rd_chk("mid_rst_enable", 3'd1, 32'h0);
    chk("mid_rst_ints", 32'(ints_out), 32'h0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
